pong_frame_sched: RTL

Per-frame game-state scheduler for the single-player pong VGA datapath.
- On each frame tick from the VGA timing block, it runs a fixed multi-cycle update sequence: paddle move, ball move, wall bounce, paddle hit/miss, score.
- It publishes a coherent position/score snapshot that the pixel renderer reads during the next visible frame.
- It sits between the button inputs and the renderer, in the pix_clk domain.

---
 rtl/pong_pkg.sv | 31 +++
 rtl/pong_bounded_step.sv | 31 +++
 rtl/pong_frame_sched.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared types and default geometry for the pong frame scheduler.
package pong_pkg;

    localparam int COORD_W = 10;

    localparam int DEF_H_RES        = 640;
    localparam int DEF_V_RES        = 480;
    localparam int DEF_PADDLE_X     = 16;
    localparam int DEF_PADDLE_W     = 8;
    localparam int DEF_PADDLE_H     = 64;
    localparam int DEF_BALL_SZ      = 8;
    localparam int DEF_PADDLE_STEP  = 4;
    localparam int DEF_BALL_STEP    = 2;
    localparam int DEF_SERVE_FRAMES = 60;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PADDLE,
        S_BALL,
        S_WALL,
        S_HIT,
        S_PUBLISH
    } state_e;

    // POS = right on x, down on y
    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_e;

endpackage

// File: rtl/pong_bounded_step.sv
// Combinational saturating step of a coordinate within [lo_i, hi_i].
module pong_bounded_step
    import pong_pkg::*;
#(
    parameter int W = COORD_W
) (
    input  logic [W-1:0] val_i,
    input  logic [W-1:0] step_i,
    input  logic [W-1:0] lo_i,
    input  logic [W-1:0] hi_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] val_o
);

    logic [W:0] sum;
    logic [W:0] floor_lim;

    // One bit of headroom so neither direction can wrap.
    always_comb begin
        sum       = {1'b0, val_i} + {1'b0, step_i};
        floor_lim = {1'b0, lo_i} + {1'b0, step_i};
        val_o     = val_i;
        if (inc_i && !dec_i) begin
            val_o = (sum > {1'b0, hi_i}) ? hi_i : sum[W-1:0];
        end else if (dec_i && !inc_i) begin
            val_o = ({1'b0, val_i} < floor_lim) ? lo_i : (val_i - step_i);
        end
    end

endmodule

// File: rtl/pong_frame_sched.sv
// Per-frame pong game-state update sequencer with a published snapshot for the renderer.
// Optional paddle auto-tracking (attract mode) is built when PONG_ATTRACT_EN is defined.
//
// state     | meaning
// S_IDLE    | waiting for i_frame, buttons latched on the tick
// S_PADDLE  | paddle moved by latched buttons (or auto-track)
// S_BALL    | serve countdown or ball step on both axes
// S_WALL    | top/bottom/right wall clamp and bounce
// S_HIT     | paddle hit or miss resolution
// S_PUBLISH | working registers copied to outputs
module pong_frame_sched
    import pong_pkg::*;
#(
    parameter int H_RES        = DEF_H_RES,
    parameter int V_RES        = DEF_V_RES,
    parameter int PADDLE_X     = DEF_PADDLE_X,
    parameter int PADDLE_W     = DEF_PADDLE_W,
    parameter int PADDLE_H     = DEF_PADDLE_H,
    parameter int BALL_SZ      = DEF_BALL_SZ,
    parameter int PADDLE_STEP  = DEF_PADDLE_STEP,
    parameter int BALL_STEP    = DEF_BALL_STEP,
    parameter int SERVE_FRAMES = DEF_SERVE_FRAMES
) (
    input  logic               pix_clk,
    input  logic               pix_rst,
    input  logic               i_frame,
    input  logic               i_move_up,
    input  logic               i_move_down,
    output logic [COORD_W-1:0] o_paddle_y,
    output logic [COORD_W-1:0] o_ball_x,
    output logic [COORD_W-1:0] o_ball_y,
    output logic [7:0]         o_score,
    output logic               o_busy,
    output logic               o_miss
);

    localparam int SERVE_W = $clog2(SERVE_FRAMES + 1);

    localparam logic [COORD_W-1:0] PAD_Y_MAX  = COORD_W'(V_RES - PADDLE_H);
    localparam logic [COORD_W-1:0] PAD_Y_RST  = COORD_W'((V_RES - PADDLE_H) / 2);
    localparam logic [COORD_W-1:0] BX_MAX     = COORD_W'(H_RES - BALL_SZ);
    localparam logic [COORD_W-1:0] BY_MAX     = COORD_W'(V_RES - BALL_SZ);
    localparam logic [COORD_W-1:0] BX_CTR     = COORD_W'((H_RES - BALL_SZ) / 2);
    localparam logic [COORD_W-1:0] BY_CTR     = COORD_W'((V_RES - BALL_SZ) / 2);
    localparam logic [COORD_W-1:0] HIT_X      = COORD_W'(PADDLE_X + PADDLE_W);
    localparam logic [COORD_W-1:0] PAD_X_C    = COORD_W'(PADDLE_X);
    localparam logic [COORD_W-1:0] PAD_STEP_C = COORD_W'(PADDLE_STEP);
    localparam logic [COORD_W-1:0] BAL_STEP_C = COORD_W'(BALL_STEP);
    localparam logic [COORD_W:0]   BALL_SZ_W  = (COORD_W+1)'(BALL_SZ);
    localparam logic [COORD_W:0]   PAD_H_W    = (COORD_W+1)'(PADDLE_H);
    localparam logic [COORD_W:0]   PAD_X_W    = (COORD_W+1)'(PADDLE_X);
    localparam logic [SERVE_W-1:0] SERVE_RST  = SERVE_W'(SERVE_FRAMES);

    state_e               state_q, state_d;
    logic [COORD_W-1:0]   paddle_q, paddle_d;
    logic [COORD_W-1:0]   bx_q, bx_d;
    logic [COORD_W-1:0]   by_q, by_d;
    dir_e                 dirx_q, dirx_d;
    dir_e                 diry_q, diry_d;
    logic [7:0]           score_q, score_d;
    logic [SERVE_W-1:0]   serve_q, serve_d;
    logic                 up_q, up_d;
    logic                 dn_q, dn_d;
    logic                 miss_q, miss_d;
    logic [COORD_W-1:0]   pub_pad_q, pub_pad_d;
    logic [COORD_W-1:0]   pub_bx_q, pub_bx_d;
    logic [COORD_W-1:0]   pub_by_q, pub_by_d;
    logic [7:0]           pub_score_q, pub_score_d;

    logic [COORD_W-1:0]   paddle_step, bx_step, by_step;
    logic [COORD_W:0]     bx_ext, by_ext, pad_ext;
    logic                 hit;
    logic                 pad_up, pad_dn, score_freeze;

    assign bx_ext  = {1'b0, bx_q};
    assign by_ext  = {1'b0, by_q};
    assign pad_ext = {1'b0, paddle_q};

    assign hit = (bx_q <= HIT_X) && ((bx_ext + BALL_SZ_W) > PAD_X_W) &&
                 ((by_ext + BALL_SZ_W) > pad_ext) && (by_ext < (pad_ext + PAD_H_W));

`ifdef PONG_ATTRACT_EN
    logic [8:0]       idle_q, idle_d;
    logic             auto_q, auto_d;
    logic [COORD_W:0] ball_c, pad_c;

    assign ball_c = by_ext + (COORD_W+1)'(BALL_SZ / 2);
    assign pad_c  = pad_ext + (COORD_W+1)'(PADDLE_H / 2);

    // Idle counter saturates at 256; tracking starts on the frame it gets there.
    always_comb begin
        idle_d = idle_q;
        auto_d = auto_q;
        if (state_q == S_IDLE && i_frame) begin
            if (i_move_up || i_move_down) begin
                idle_d = '0;
            end else if (!idle_q[8]) begin
                idle_d = idle_q + 9'd1;
            end
            auto_d = idle_d[8];
        end
    end

    always_ff @(posedge pix_clk) begin
        if (pix_rst) begin
            idle_q <= '0;
            auto_q <= 1'b0;
        end else begin
            idle_q <= idle_d;
            auto_q <= auto_d;
        end
    end

    assign pad_up       = auto_q ? ((ball_c + (COORD_W+1)'(PADDLE_STEP)) < pad_c) : up_q;
    assign pad_dn       = auto_q ? (ball_c > (pad_c + (COORD_W+1)'(PADDLE_STEP))) : dn_q;
    assign score_freeze = auto_q;
`else
    assign pad_up       = up_q;
    assign pad_dn       = dn_q;
    assign score_freeze = 1'b0;
`endif

    pong_bounded_step #(.W(COORD_W)) u_step_paddle (
        .val_i  (paddle_q),
        .step_i (PAD_STEP_C),
        .lo_i   ('0),
        .hi_i   (PAD_Y_MAX),
        .inc_i  (pad_dn),
        .dec_i  (pad_up),
        .val_o  (paddle_step)
    );

    pong_bounded_step #(.W(COORD_W)) u_step_bx (
        .val_i  (bx_q),
        .step_i (BAL_STEP_C),
        .lo_i   ('0),
        .hi_i   (BX_MAX),
        .inc_i  (dirx_q == DIR_POS),
        .dec_i  (dirx_q == DIR_NEG),
        .val_o  (bx_step)
    );

    pong_bounded_step #(.W(COORD_W)) u_step_by (
        .val_i  (by_q),
        .step_i (BAL_STEP_C),
        .lo_i   ('0),
        .hi_i   (BY_MAX),
        .inc_i  (diry_q == DIR_POS),
        .dec_i  (diry_q == DIR_NEG),
        .val_o  (by_step)
    );

    always_comb begin
        state_d     = state_q;
        paddle_d    = paddle_q;
        bx_d        = bx_q;
        by_d        = by_q;
        dirx_d      = dirx_q;
        diry_d      = diry_q;
        score_d     = score_q;
        serve_d     = serve_q;
        up_d        = up_q;
        dn_d        = dn_q;
        miss_d      = miss_q;
        pub_pad_d   = pub_pad_q;
        pub_bx_d    = pub_bx_q;
        pub_by_d    = pub_by_q;
        pub_score_d = pub_score_q;

        case (state_q)
            S_IDLE: begin
                if (i_frame) begin
                    up_d    = i_move_up;
                    dn_d    = i_move_down;
                    miss_d  = 1'b0;
                    state_d = S_PADDLE;
                end
            end
            S_PADDLE: begin
                paddle_d = paddle_step;
                state_d  = S_BALL;
            end
            S_BALL: begin
                if (serve_q != '0) begin
                    serve_d = serve_q - 1'b1;
                end else begin
                    bx_d = bx_step;
                    by_d = by_step;
                end
                state_d = S_WALL;
            end
            S_WALL: begin
                if (by_q == '0 && diry_q == DIR_NEG) begin
                    diry_d = DIR_POS;
                end
                if (by_q >= BY_MAX) begin
                    by_d   = BY_MAX;
                    diry_d = DIR_NEG;
                end
                if (bx_q >= BX_MAX) begin
                    bx_d   = BX_MAX;
                    dirx_d = DIR_NEG;
                end
                state_d = S_HIT;
            end
            S_HIT: begin
                if (score_freeze) begin
                    score_d = '0;
                end
                if (dirx_q == DIR_NEG && serve_q == '0) begin
                    if (hit) begin
                        bx_d   = HIT_X;
                        dirx_d = DIR_POS;
                        if (!score_freeze && score_q != 8'hFF) begin
                            score_d = score_q + 8'd1;
                        end
                    end else if (bx_q < PAD_X_C) begin
                        miss_d  = 1'b1;
                        score_d = '0;
                        bx_d    = BX_CTR;
                        by_d    = BY_CTR;
                        dirx_d  = DIR_POS;
                        serve_d = SERVE_RST;
                    end
                end
                state_d = S_PUBLISH;
            end
            S_PUBLISH: begin
                pub_pad_d   = paddle_q;
                pub_bx_d    = bx_q;
                pub_by_d    = by_q;
                pub_score_d = score_q;
                miss_d      = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pix_clk) begin
        if (pix_rst) begin
            state_q     <= S_IDLE;
            paddle_q    <= PAD_Y_RST;
            bx_q        <= BX_CTR;
            by_q        <= BY_CTR;
            dirx_q      <= DIR_POS;
            diry_q      <= DIR_POS;
            score_q     <= '0;
            serve_q     <= SERVE_RST;
            up_q        <= 1'b0;
            dn_q        <= 1'b0;
            miss_q      <= 1'b0;
            pub_pad_q   <= PAD_Y_RST;
            pub_bx_q    <= BX_CTR;
            pub_by_q    <= BY_CTR;
            pub_score_q <= '0;
        end else begin
            state_q     <= state_d;
            paddle_q    <= paddle_d;
            bx_q        <= bx_d;
            by_q        <= by_d;
            dirx_q      <= dirx_d;
            diry_q      <= diry_d;
            score_q     <= score_d;
            serve_q     <= serve_d;
            up_q        <= up_d;
            dn_q        <= dn_d;
            miss_q      <= miss_d;
            pub_pad_q   <= pub_pad_d;
            pub_bx_q    <= pub_bx_d;
            pub_by_q    <= pub_by_d;
            pub_score_q <= pub_score_d;
        end
    end

    assign o_paddle_y = pub_pad_q;
    assign o_ball_x   = pub_bx_q;
    assign o_ball_y   = pub_by_q;
    assign o_score    = pub_score_q;
    assign o_busy     = (state_q != S_IDLE);
    assign o_miss     = (state_q == S_PUBLISH) && miss_q;

endmodule
